mem_stall_ctrl: RTL and testbench
=================================

MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of the data bus and the address bus.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of bus-wait cycles before an access is aborted (range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port MemReadM, input, 1 bit: the MEM-stage instruction is a load.
REQ-006 SHALL have port MemWriteM, input, 1 bit: the MEM-stage instruction is a store.
REQ-007 SHALL have port ALUResultM, input, DATA_WIDTH bits: the access address.
REQ-008 SHALL have port WriteDataM, input, DATA_WIDTH bits: the store data.
REQ-009 SHALL have port ByteEnM, input, 4 bits: the store byte enables.
REQ-010 SHALL have port mem_stall, output, 1 bit: holds the pipeline, including the MEM/WB register.
REQ-011 SHALL have port DMRd, output, DATA_WIDTH bits: the load data sent to the MEM/WB register.
REQ-012 SHALL have port bus_req, output, 1 bit: a bus request is pending.
REQ-013 SHALL have port bus_we, output, 1 bit: 1 means write, 0 means read.
REQ-014 SHALL have the following bus output ports: bus_addr (DATA_WIDTH bits), bus_wdata (DATA_WIDTH bits) and bus_be (4 bits).
REQ-015 SHALL have port bus_ack, input, 1 bit: the memory completes the pending request.
REQ-016 SHALL have port bus_rdata, input, DATA_WIDTH bits: the read data; valid only when bus_ack is 1.
REQ-017 SHALL have port bus_timeout, output, 1 bit: a sticky flag showing that an access was aborted.

Function
REQ-018 SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-019 SHALL, in IDLE, drive mem_stall combinationally as MemReadM OR MemWriteM, in the same cycle the request appears.
REQ-020 SHALL, in IDLE with a request present, register the address, write data, byte enables and bus_we, then enter BUSY on the next edge.
REQ-021 SHALL treat MemReadM and MemWriteM both 1 as a write (bus_we=1), with the read ignored.
REQ-022 SHALL, in BUSY, hold bus_req=1 and mem_stall=1, with bus_addr, bus_wdata, bus_be and bus_we stable until the request completes.
REQ-023 SHALL, when bus_ack=1 in BUSY: for a read, register bus_rdata into DMRd; for a write, leave DMRd unchanged; then enter DONE.
REQ-024 SHALL, in DONE, drive mem_stall=0 and bus_req=0 for exactly one cycle, so the stalled instruction advances with DMRd valid.
REQ-025 SHALL NOT re-issue the MEM-stage request in DONE, and SHALL return to IDLE unconditionally.
REQ-026 SHALL give a minimum access time of 2 stall cycles (request cycle plus one BUSY cycle with bus_ack) before the DONE cycle.
REQ-027 SHALL, in BUSY, run an 8-bit wait counter that clears on entry to BUSY and increments each cycle without bus_ack.
REQ-028 SHALL abort the access when the wait counter reaches TIMEOUT without bus_ack: enter DONE, set bus_timeout=1 and, for a read, load DMRd with all ones.
REQ-029 SHALL, if bus_ack arrives in the same cycle that the wait counter reaches TIMEOUT, give priority to bus_ack: complete normally and leave bus_timeout unchanged.
REQ-030 SHALL ignore bus_ack when bus_req=0, in IDLE or DONE.
REQ-031 SHALL hold DMRd at its last loaded value between accesses.
REQ-032 SHALL clear bus_timeout only on rst.

Reset
REQ-033 SHALL, with rst=1 at a clock edge, set the state to IDLE and clear the wait counter.
REQ-034 SHALL, with rst=1 at a clock edge, set DMRd, bus_addr, bus_wdata, bus_be, bus_we, bus_req and bus_timeout to 0.
REQ-035 SHALL, on reset during BUSY, drop bus_req at that edge and abandon the pending access, with no DONE cycle.
REQ-036 SHALL drive mem_stall=0 while rst=1, and SHALL drive mem_stall combinationally from the request inputs in IDLE after reset is released.

Verification
REQ-037 SHALL be verified with this scenario: read of address 0x100; memory gives bus_ack with bus_rdata 0xCAFEF00D on the first BUSY cycle -> mem_stall=1 for 2 cycles, then 0 for 1 cycle, with DMRd=0xCAFEF00D in the DONE cycle.
REQ-038 SHALL be verified with this scenario: write of 0x12345678 to address 0x200 with ByteEnM=0xF; bus_ack after 5 cycles -> bus_we=1, bus_addr=0x200 and bus_wdata=0x12345678 stable for 5 cycles, with DMRd unchanged.
REQ-039 SHALL be verified with this scenario: TIMEOUT=4, read with no bus_ack -> DONE after 4 BUSY cycles, DMRd=0xFFFFFFFF and bus_timeout=1 held until rst.
REQ-040 SHALL be verified with this scenario: MemReadM=MemWriteM=1 -> a write is issued (bus_we=1).
REQ-041 SHALL be verified with this scenario: back-to-back loads -> the second is issued in the IDLE cycle after DONE, never in DONE.
REQ-042 SHALL be verified with this scenario: rst asserted on the third BUSY cycle -> bus_req=0 and state IDLE on the next cycle, with DMRd=0 and a stray bus_ack afterwards ignored.

Source files
------------

// File: rtl/mem_stall_ctrl.sv
// Stalls the pipeline around a single outstanding data-memory bus access,
// with a bounded bus wait and a sticky abort flag.
module mem_stall_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [3:0]            ByteEnM,
  output logic                  mem_stall,
  output logic [DATA_WIDTH-1:0] DMRd,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DATA_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_be,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Counter value of the last BUSY cycle the bus may still answer in.
  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

  state_t                r_state;
  logic [7:0]            r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_dmrd;
  logic                  r_bus_req;
  logic                  r_bus_we;
  logic [DATA_WIDTH-1:0] r_bus_addr;
  logic [DATA_WIDTH-1:0] r_bus_wdata;
  logic [3:0]            r_bus_be;
  logic                  r_bus_timeout;

  logic                  w_req;
  logic                  w_stall;

  assign w_req = MemReadM | MemWriteM;

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch.
    w_stall = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE:    w_stall = w_req;
        BUSY:    w_stall = 1'b1;
        default: w_stall = 1'b0;
      endcase
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_wait_cnt    <= 8'd0;
      r_dmrd        <= '0;
      r_bus_req     <= 1'b0;
      r_bus_we      <= 1'b0;
      r_bus_addr    <= '0;
      r_bus_wdata   <= '0;
      r_bus_be      <= 4'd0;
      r_bus_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_bus_addr  <= ALUResultM;
            r_bus_wdata <= WriteDataM;
            r_bus_be    <= ByteEnM;
            r_bus_we    <= MemWriteM;
            r_bus_req   <= 1'b1;
            r_wait_cnt  <= 8'd0;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          if (bus_ack) begin
            if (!r_bus_we) r_dmrd <= bus_rdata;
            r_bus_req <= 1'b0;
            r_state   <= DONE;
          end else if (r_wait_cnt == LP_LAST_WAIT) begin
            if (!r_bus_we) r_dmrd <= '1;
            r_bus_timeout <= 1'b1;
            r_bus_req     <= 1'b0;
            r_state       <= DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_stall   = w_stall;
  assign DMRd        = r_dmrd;
  assign bus_req     = r_bus_req;
  assign bus_we      = r_bus_we;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign bus_be      = r_bus_be;
  assign bus_timeout = r_bus_timeout;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Scoreboard bench: a default-TIMEOUT unit checked by a DONE-cycle monitor,
// plus a TIMEOUT=4 unit on the same inputs for the wait-bound scenarios.
module tb_mem_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [3:0]  ByteEnM;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  logic        mem_stall, bus_req, bus_we, bus_timeout;
  logic [31:0] DMRd, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  logic        mem_stall2, bus_req2, bus_we2, bus_timeout2;
  logic [31:0] DMRd2, bus_addr2, bus_wdata2;
  logic [3:0]  bus_be2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] dmrd;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          busy;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_stall_ctrl u_dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ByteEnM(ByteEnM),
    .mem_stall(mem_stall), .DMRd(DMRd), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_timeout(bus_timeout)
  );

  mem_stall_ctrl #(.DATA_WIDTH(32), .TIMEOUT(4)) u_dut_to (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ByteEnM(ByteEnM),
    .mem_stall(mem_stall2), .DMRd(DMRd2), .bus_req(bus_req2), .bus_we(bus_we2),
    .bus_addr(bus_addr2), .bus_wdata(bus_wdata2), .bus_be(bus_be2),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_timeout(bus_timeout2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: tracks each bus request window and scores it on the DONE cycle.
  logic        m_prev_req = 1'b0;
  int          m_busy = 0;
  logic        m_stable = 1'b1;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      m_prev_req = 1'b0;
      m_busy     = 0;
    end else begin
      if (bus_req) begin
        if (!m_prev_req) begin
          m_we = bus_we; m_addr = bus_addr; m_wdata = bus_wdata; m_be = bus_be;
          m_busy = 1; m_stable = 1'b1;
        end else begin
          m_busy++;
          if (bus_we !== m_we || bus_addr !== m_addr || bus_wdata !== m_wdata || bus_be !== m_be)
            m_stable = 1'b0;
        end
      end else if (m_prev_req) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("done_dmrd",    DMRd, e.dmrd);
          check("done_stall",   32'(mem_stall), 32'd0);
          check("done_timeout", 32'(bus_timeout), 32'd0);
          check("bus_we",       32'(m_we), 32'(e.we));
          check("bus_addr",     m_addr, e.addr);
          check("bus_wdata",    m_wdata, e.wdata);
          check("bus_be",       32'(m_be), 32'(e.be));
          check("busy_cycles",  32'(m_busy), 32'(e.busy));
          check("bus_stable",   32'(m_stable), 32'd1);
        end
      end
      m_prev_req = bus_req;
    end
  end

  // One MEM-stage access on the main unit; inputs stay held through DONE.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int ack_after, input logic [31:0] rdata,
                        input logic [31:0] exp_dmrd);
    exp_t e;
    int n;
    e.dmrd = exp_dmrd; e.we = wr; e.addr = addr; e.wdata = wdata; e.be = be;
    e.busy = ack_after;
    sb.push_back(e);
    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; ALUResultM = addr; WriteDataM = wdata;
    ByteEnM = be; bus_ack = 1'b0;
    #1;
    check("req_stall", 32'(mem_stall), 32'd1);
    check("req_no_bus", 32'(bus_req), 32'd0);
    n = 0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (!bus_req) break;
      n++;
      check("busy_stall", 32'(mem_stall), 32'd1);
      if (n > 300) begin
        check("busy_bound", 32'(n), 32'(ack_after));
        break;
      end
      bus_ack   = (n == ack_after);
      bus_rdata = (n == ack_after) ? rdata : 32'hDEAD_BEEF;
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      MemReadM = 1'b0; MemWriteM = 1'b0; bus_ack = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h0;
    WriteDataM = 32'h0; ByteEnM = 4'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_stall",   32'(mem_stall), 32'd0);
    check("rst_dmrd",    DMRd, 32'd0);
    check("rst_req",     32'(bus_req), 32'd0);
    check("rst_we",      32'(bus_we), 32'd0);
    check("rst_addr",    bus_addr, 32'd0);
    check("rst_timeout", 32'(bus_timeout), 32'd0);
    rst = 1'b0; MemReadM = 1'b0;

    access(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D);
    idle(1);
    access(1'b0, 1'b1, 32'h200, 32'h1234_5678, 4'hF, 5, 32'h0, 32'hCAFE_F00D);
    idle(1);
    access(1'b1, 1'b1, 32'h300, 32'hA5A5_A5A5, 4'h3, 2, 32'h1111_1111, 32'hCAFE_F00D);
    idle(1);
    // Back-to-back loads: the second request cycle must see bus_req still low.
    access(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, 1, 32'h0102_0304, 32'h0102_0304);
    access(1'b1, 1'b0, 32'h404, 32'h0, 4'h0, 3, 32'h0506_0708, 32'h0506_0708);

    @(negedge clk);
    MemReadM = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0BAD_0BAD;
    repeat (2) @(negedge clk);
    check("idle_ack_req",  32'(bus_req), 32'd0);
    check("idle_ack_dmrd", DMRd, 32'h0506_0708);
    bus_ack = 1'b0;

    // Bus answers on the last permitted cycle of the TIMEOUT=4 unit.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    access(1'b1, 1'b0, 32'h500, 32'h0, 4'h0, 4, 32'h55AA_55AA, 32'h55AA_55AA);
    check("edge_ack_dmrd2", DMRd2, 32'h55AA_55AA);
    check("edge_ack_to2",   32'(bus_timeout2), 32'd0);
    check("edge_ack_req2",  32'(bus_req2), 32'd0);

    // Reset during the third BUSY cycle abandons the access.
    @(negedge clk);
    MemReadM = 1'b1; ALUResultM = 32'h600; bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_req", 32'(bus_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_req",   32'(bus_req), 32'd0);
    check("abort_stall", 32'(mem_stall), 32'd0);
    check("abort_dmrd",  DMRd, 32'd0);
    rst = 1'b0; MemReadM = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    check("stray_ack_req",  32'(bus_req), 32'd0);
    check("stray_ack_dmrd", DMRd, 32'd0);
    check("stray_ack_stall", 32'(mem_stall), 32'd0);
    bus_ack = 1'b0;

    // TIMEOUT=4 unit: read with no answer aborts after four BUSY cycles.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; MemReadM = 1'b1; ALUResultM = 32'h700;
    #1;
    check("to_req_stall2", 32'(mem_stall2), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("to_busy%0d_req2", i), 32'(bus_req2), 32'd1);
    end
    @(negedge clk);
    check("to_done_req2",   32'(bus_req2), 32'd0);
    check("to_done_stall2", 32'(mem_stall2), 32'd0);
    check("to_done_dmrd2",  DMRd2, 32'hFFFF_FFFF);
    check("to_done_flag2",  32'(bus_timeout2), 32'd1);
    idle(4);
    check("to_sticky2", 32'(bus_timeout2), 32'd1);
    check("to_sticky_dmrd2", DMRd2, 32'hFFFF_FFFF);
    rst = 1'b1;
    @(negedge clk);
    check("to_cleared2", 32'(bus_timeout2), 32'd0);
    rst = 1'b0;
    idle(2);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
